// File: rtl/serial_work_transmit.sv
// serial_work_transmit: serializes one 672-bit work frame {data, nonce, target1}
// MSB-first as NBYTES bytes onto a byte-level UART transmitter handshake.
// Each byte is strobed for one cycle, followed by a fixed two-cycle hold so the
// transmitter can drop tx_ready, then a wait for tx_ready before the next byte.
module serial_work_transmit #(
   parameter int NBYTES     = 84,   // bytes per frame; must equal 672/8
   parameter int GAP_CYCLES = 0     // idle clocks between bytes (0..255)
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         send,
   input  logic [607:0] data,
   input  logic [31:0]  nonce,
   input  logic [31:0]  target1,
   output logic         busy,
   output logic         done,
   output logic [7:0]   tx_byte,
   output logic         tx_new_byte,
   input  logic         tx_ready
);

   localparam int         FRAME_W  = NBYTES * 8;
   localparam logic [6:0] LAST_CNT = 7'(NBYTES);
   localparam logic [7:0] GAP_LAST = 8'(GAP_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT_RDY,
      S_HOLD,
      S_WAIT_DONE,
      S_GAP,
      S_FINISH
   } state_t;

   state_t               state_q, state_d;
   logic [FRAME_W-1:0]   shift_q, shift_d;
   logic [6:0]           cnt_q, cnt_d;      // bytes already handed off
   logic                 hold_q, hold_d;    // second HOLD cycle marker
   logic [7:0]           gap_q, gap_d;
   logic [7:0]           tx_byte_q, tx_byte_d;

   // State and datapath registers; reset aborts any frame in flight.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= S_IDLE;
         shift_q   <= '0;
         cnt_q     <= '0;
         hold_q    <= 1'b0;
         gap_q     <= '0;
         tx_byte_q <= '0;
      end else begin
         state_q   <= state_d;
         shift_q   <= shift_d;
         cnt_q     <= cnt_d;
         hold_q    <= hold_d;
         gap_q     <= gap_d;
         tx_byte_q <= tx_byte_d;
      end
   end

   // Next-state logic and handshake outputs.
   always_comb begin
      state_d     = state_q;
      shift_d     = shift_q;
      cnt_d       = cnt_q;
      hold_d      = hold_q;
      gap_d       = gap_q;
      tx_byte_d   = tx_byte_q;
      tx_new_byte = 1'b0;
      busy        = (state_q == S_WAIT_RDY) || (state_q == S_HOLD) ||
                    (state_q == S_WAIT_DONE) || (state_q == S_GAP);
      done        = (state_q == S_FINISH);

      case (state_q)
         S_IDLE: begin
            if (send) begin
               shift_d = {data, nonce, target1};
               cnt_d   = '0;
               state_d = S_WAIT_RDY;
            end
         end
         S_WAIT_RDY: begin
            if (tx_ready) begin
               tx_new_byte = 1'b1;
               tx_byte_d   = shift_q[FRAME_W-1 -: 8];
               shift_d     = shift_q << 8;
               cnt_d       = cnt_q + 7'd1;
               hold_d      = 1'b0;
               state_d     = S_HOLD;
            end
         end
         S_HOLD: begin
            // tx_ready is deliberately ignored here: the transmitter may still
            // show ready for a cycle or two after accepting the byte.
            if (hold_q) begin
               state_d = S_WAIT_DONE;
            end else begin
               hold_d = 1'b1;
            end
         end
         S_WAIT_DONE: begin
            if (tx_ready) begin
               if (cnt_q == LAST_CNT) begin
                  state_d = S_FINISH;
               end else if (GAP_CYCLES > 0) begin
                  gap_d   = '0;
                  state_d = S_GAP;
               end else begin
                  state_d = S_WAIT_RDY;
               end
            end
         end
         S_GAP: begin
            if (gap_q == GAP_LAST) begin
               state_d = S_WAIT_RDY;
            end else begin
               gap_d = gap_q + 8'd1;
            end
         end
         S_FINISH: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // The byte is presented in the strobe cycle and then held until the next strobe.
   always_comb begin
      tx_byte = tx_new_byte ? shift_q[FRAME_W-1 -: 8] : tx_byte_q;
   end

endmodule
